// File: rtl/display_arbiter_if.sv
// Display bus shared by the arbiter and its three requesters.
// The slave side is the arbiter; the master side drives requests and words.
interface display_arbiter_if;
  logic [2:0]  req;
  logic [15:0] value0;
  logic [15:0] value1;
  logic [15:0] value2;
  logic [3:0]  point0;
  logic [3:0]  point1;
  logic [3:0]  point2;
  logic [15:0] value;
  logic [3:0]  point;
  logic [2:0]  grant;
  logic        switched;

  modport slave (
    input  req, value0, value1, value2, point0, point1, point2,
    output value, point, grant, switched
  );

  modport master (
    output req, value0, value1, value2, point0, point1, point2,
    input  value, point, grant, switched
  );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter that lends a 4-digit display to one of three requesters.
// An owner keeps the display for at least HOLD_CYCLES cycles; after that it
// yields to any other waiting requester, or keeps it if nobody else asks.
module display_arbiter #(
  parameter logic [23:0] HOLD_CYCLES = 24'd10_000_000
) (
  input  logic              clock,
  input  logic              reset,
  display_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t      r_state;
  logic [23:0] r_cnt;
  logic [1:0]  r_rr;
  logic [2:0]  r_grant;
  logic [15:0] r_value;
  logic [3:0]  r_point;
  logic        r_switched;

  logic [2:0]  w_cand;
  logic [2:0]  w_pick;
  logic        w_win_ok;
  logic [1:0]  w_win;
  logic [1:0]  w_rr_next;
  logic [15:0] w_win_val;
  logic [3:0]  w_win_pt;
  logic        w_own_req;
  logic [15:0] w_own_val;
  logic [3:0]  w_own_pt;

  // First asserted candidate starting at rr and wrapping mod 3; {found, index}.
  function automatic logic [2:0] f_pick(input logic [2:0] cand, input logic [1:0] rr);
    logic [2:0] res;
    int         t;
    res = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      t = int'(rr) + k;
      if (t >= 3) t = t - 3;
      if (cand[t]) res = {1'b1, 2'(t)};
    end
    return res;
  endfunction

  function automatic logic [15:0] f_val(input logic [1:0] idx, input logic [15:0] v0,
                                        input logic [15:0] v1, input logic [15:0] v2);
    return (idx == 2'd0) ? v0 : (idx == 2'd1) ? v1 : v2;
  endfunction

  function automatic logic [3:0] f_pt(input logic [1:0] idx, input logic [3:0] p0,
                                      input logic [3:0] p1, input logic [3:0] p2);
    return (idx == 2'd0) ? p0 : (idx == 2'd1) ? p1 : p2;
  endfunction

  // Arbitration candidates exclude the current owner, so only others can take over.
  always_comb begin
    w_cand    = (r_state == SHOW) ? (bus.req & ~r_grant) : bus.req;
    w_pick    = f_pick(w_cand, r_rr);
    w_win_ok  = w_pick[2];
    w_win     = w_pick[1:0];
    w_rr_next = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
    w_win_val = f_val(w_win, bus.value0, bus.value1, bus.value2);
    w_win_pt  = f_pt(w_win, bus.point0, bus.point1, bus.point2);
    w_own_req = |(bus.req & r_grant);
    w_own_val = r_grant[0] ? bus.value0 : r_grant[1] ? bus.value1 : bus.value2;
    w_own_pt  = r_grant[0] ? bus.point0 : r_grant[1] ? bus.point1 : bus.point2;
  end

  // Ownership FSM with hold counter and registered display outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 24'd0;
      r_rr       <= 2'd0;
      r_grant    <= 3'b000;
      r_value    <= 16'h0000;
      r_point    <= 4'h0;
      r_switched <= 1'b0;
    end else begin
      r_switched <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_win_ok) begin
            r_state    <= SHOW;
            r_grant    <= 3'(3'b001 << w_win);
            r_rr       <= w_rr_next;
            r_cnt      <= 24'(HOLD_CYCLES - 24'd1);
            r_value    <= w_win_val;
            r_point    <= w_win_pt;
            r_switched <= 1'b1;
          end
        end
        SHOW: begin
          if (r_cnt != 24'd0) begin
            r_cnt <= r_cnt - 24'd1;
            if (w_own_req) begin
              r_value <= w_own_val;
              r_point <= w_own_pt;
            end
          end else if (w_win_ok) begin
            r_grant    <= 3'(3'b001 << w_win);
            r_rr       <= w_rr_next;
            r_cnt      <= 24'(HOLD_CYCLES - 24'd1);
            r_value    <= w_win_val;
            r_point    <= w_win_pt;
            r_switched <= 1'b1;
          end else if (w_own_req) begin
            r_value <= w_own_val;
            r_point <= w_own_pt;
          end else begin
            r_state    <= IDLE;
            r_grant    <= 3'b000;
            r_value    <= 16'h0000;
            r_point    <= 4'h0;
            r_switched <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.value    = r_value;
  assign bus.point    = r_point;
  assign bus.grant    = r_grant;
  assign bus.switched = r_switched;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter with a four-cycle hold: directed vectors with
// literal expectations plus a cycle-by-cycle comparison against an
// ownership model built on "owner, age since grant, round-robin start".
module tb_display_arbiter;
  localparam logic [23:0] HOLD = 24'd4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  display_arbiter_if bus();

  display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_own = -1;
  int          m_age = 0;
  int          m_rr  = 0;
  logic [15:0] m_val = 16'h0;
  logic [3:0]  m_pt  = 4'h0;
  logic [2:0]  m_gnt = 3'b000;
  logic        m_sw  = 1'b0;

  function automatic int pick(input logic [2:0] c, input int rr);
    for (int k = 0; k < 3; k++) begin
      if (c[(rr + k) % 3]) return (rr + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [15:0] val_of(input int i);
    return (i == 0) ? bus.value0 : (i == 1) ? bus.value1 : bus.value2;
  endfunction

  function automatic logic [3:0] pt_of(input int i);
    return (i == 0) ? bus.point0 : (i == 1) ? bus.point1 : bus.point2;
  endfunction

  task automatic m_take(input int w);
    m_sw  = 1'b1;
    m_own = w;
    m_age = 0;
    m_rr  = (w + 1) % 3;
    m_gnt = 3'(1 << w);
    m_val = val_of(w);
    m_pt  = pt_of(w);
  endtask

  initial begin
    forever begin : model_step
      logic [2:0] r;
      int         w;
      bit         expired;
      @(posedge clk or posedge rst);
      if (rst) begin
        m_own = -1; m_age = 0; m_rr = 0;
        m_val = 16'h0; m_pt = 4'h0; m_gnt = 3'b000; m_sw = 1'b0;
      end else begin
        r    = bus.req;
        m_sw = 1'b0;
        if (m_own < 0) begin
          w = pick(r, m_rr);
          if (w >= 0) m_take(w);
        end else begin
          expired = (m_age >= int'(HOLD) - 1);
          m_age++;
          if (!expired) begin
            if (r[m_own]) begin m_val = val_of(m_own); m_pt = pt_of(m_own); end
          end else begin
            w = pick(r & ~m_gnt, m_rr);
            if (w >= 0) m_take(w);
            else if (r[m_own]) begin m_val = val_of(m_own); m_pt = pt_of(m_own); end
            else begin
              m_own = -1; m_gnt = 3'b000; m_val = 16'h0; m_pt = 4'h0; m_sw = 1'b1;
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison, sampled just after each rising edge settles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("grant",    16'(bus.grant),    16'(m_gnt));
      chk("value",    bus.value,         m_val);
      chk("point",    16'(bus.point),    16'(m_pt));
      chk("switched", 16'(bus.switched), 16'(m_sw));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  logic [2:0]  exp_g [5];
  logic [15:0] exp_v [7];

  initial begin
    bus.req    = 3'b000;
    bus.value0 = 16'hAAAA; bus.value1 = 16'hBBBB; bus.value2 = 16'hCCCC;
    bus.point0 = 4'h1;     bus.point1 = 4'h2;     bus.point2 = 4'h4;
    #1 rst = 1'b1;
    tick(2);
    rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_grant", 16'(bus.grant), 16'h0);
      chk("idle_value", bus.value, 16'h0);
      chk("idle_sw",    16'(bus.switched), 16'h0);
    end

    // simultaneous 0 and 2
    bus.req = 3'b101;
    tick(1);
    chk("r101_grant0", 16'(bus.grant), 16'h1);
    chk("r101_value0", bus.value, 16'hAAAA);
    chk("r101_point0", 16'(bus.point), 16'h1);
    chk("r101_sw0",    16'(bus.switched), 16'h1);
    tick(1);
    chk("r101_sw_low", 16'(bus.switched), 16'h0);
    tick(3);
    chk("r101_grant2", 16'(bus.grant), 16'h4);
    chk("r101_value2", bus.value, 16'hCCCC);
    chk("r101_sw2",    16'(bus.switched), 16'h1);
    bus.req = 3'b000;
    tick(4);
    chk("r101_idle",    16'(bus.grant), 16'h0);
    chk("r101_idle_sw", 16'(bus.switched), 16'h1);

    // all three requesting: strict rotation
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    bus.req = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("rot_grant", 16'(bus.grant), 16'(exp_g[i]));
      chk("rot_sw",    16'(bus.switched), 16'h1);
      tick(3);
      chk("rot_hold",  16'(bus.grant), 16'(exp_g[i]));
    end
    bus.req = 3'b000;
    tick(1);
    chk("rot_idle", 16'(bus.grant), 16'h0);

    // requester 1 ramps its word, drops request after two cycles
    exp_v = '{16'h1230, 16'h1231, 16'h1231, 16'h1231, 16'h0000, 16'h0000, 16'h0000};
    bus.req    = 3'b010;
    bus.value1 = 16'h1230;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      chk("ramp_value", bus.value, exp_v[i-1]);
      if (i == 5) begin
        chk("ramp_idle", 16'(bus.grant), 16'h0);
        chk("ramp_sw",   16'(bus.switched), 16'h1);
      end
      bus.value1 = 16'h1230 + 16'(i);
      if (i == 2) bus.req = 3'b000;
    end
    bus.value1 = 16'hBBBB;

    // lone requester keeps the display past expiry
    bus.req = 3'b001;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      chk("lone_grant", 16'(bus.grant), 16'h1);
      chk("lone_sw",    16'(bus.switched), (i == 1) ? 16'h1 : 16'h0);
    end

    // reset in the middle of ownership by requester 1
    bus.req = 3'b010;
    tick(1);
    chk("pre_rst_grant", 16'(bus.grant), 16'h2);
    #2 rst = 1'b1;
    #1;
    chk("async_grant", 16'(bus.grant), 16'h0);
    chk("async_value", bus.value, 16'h0);
    chk("async_point", 16'(bus.point), 16'h0);
    chk("async_sw",    16'(bus.switched), 16'h0);
    tick(1);
    rst     = 1'b0;
    bus.req = 3'b011;
    tick(1);
    chk("post_rst_grant", 16'(bus.grant), 16'h1);
    chk("post_rst_value", bus.value, 16'hAAAA);
    chk("post_rst_sw",    16'(bus.switched), 16'h1);
    bus.req = 3'b000;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 24'd10_000_000: minimum clock cycles one requester owns the display after a grant; legal range 1..2^24-1.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  3  per-requester display request; bit i belongs to requester i.
REQ-005 value0, value1, value2  input  16 each  hex word offered by requester 0/1/2.
REQ-006 point0, point1, point2  input  4 each  radix-point mask offered by requester 0/1/2.
REQ-007 value  output  16  registered word for the 4-digit display driver.
REQ-008 point  output  4  registered radix-point mask for the display driver.
REQ-009 grant  output  3  registered one-hot owner; 3'b000 when idle.
REQ-010 switched  output  1  registered one-cycle pulse on every grant change, including to/from idle.

Function
REQ-011 The FSM SHALL have states IDLE and SHOW; hold counter is 24 bits; rr pointer is 2 bits (values 0..2).
REQ-012 IDLE: grant=000, value=16'h0000, point=4'h0; if req!=0, next edge SHALL enter SHOW with winner per REQ-013.
REQ-013 Winner SHALL be first asserted requester searching rr, rr+1, rr+2 (mod 3); on grant, rr SHALL become winner+1 mod 3.
REQ-014 On entering SHOW or switching owner, counter SHALL load HOLD_CYCLES-1 and value/point SHALL load the winner's inputs in the same edge (1-cycle latency req->grant/value).
REQ-015 In SHOW with owner req high, value/point SHALL re-register owner's inputs every cycle (1-cycle latency).
REQ-016 In SHOW with owner req low, value/point SHALL freeze at last registered contents.
REQ-017 In SHOW the counter SHALL decrement by 1 per cycle while nonzero and SHALL saturate at 0, never wrapping.
REQ-018 At counter==0: another req asserted -> switch to winner per REQ-013 (owner excluded unless it wins via rr order); else owner req high -> stay, counter stays 0; else -> IDLE.
REQ-019 Owner req dropping then re-rising before expiry SHALL not alter grant or counter.
REQ-020 Simultaneous requests in IDLE SHALL resolve by REQ-013 alone; no requester is starved more than 2 hold periods.
REQ-021 switched SHALL be 1 exactly in the cycle after any edge where grant changed, else 0.
REQ-022 HOLD_CYCLES=1 SHALL yield counter 0 immediately on grant, permitting a switch on the next edge.

Reset
REQ-023 On reset assertion, independent of clock: state=IDLE, grant=000, value=16'h0000, point=4'h0, switched=0, counter=0, rr=0.
REQ-024 Reset asserted mid-SHOW SHALL abort ownership; first edge after release behaves as IDLE per REQ-012.

Verification (bench HOLD_CYCLES=4)
REQ-025 Reset, req=000 -> grant=000, value=0000, point=0, switched=0 held for 10 cycles.
REQ-026 req=101 simultaneously after reset -> edge1 grant=001, value=value0, switched=1; 4 cycles later grant=100, value=value2.
REQ-027 req=010, value1 ramps 0x1230..0x1237 per cycle -> value follows with 1-cycle lag; drop req at cycle 2 -> value frozen at 0x1231, IDLE after counter hits 0, switched pulses.
REQ-028 req=111 held for 20 cycles -> grant sequence 001,010,100,001,010 each lasting 4 cycles, switched pulse at each change.
REQ-029 req=001 alone held for 12 cycles -> grant stays 001, switched pulses once, counter saturates at 0.
REQ-030 Reset pulsed mid-SHOW with grant=010 -> outputs zero asynchronously; after release with req=011 -> grant=001 (rr=0).
